// File: rtl/bus_params_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_params_pkg
// Purpose  : Shared fetch-bus widths used as defaults across the slice.
// Revision : 1.0 - initial release
// ============================================================================
package bus_params_pkg;
    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
endpackage
`default_nettype wire

// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_pkg
// Purpose  : Response entry type, stall LFSR constants and address helpers.
// Revision : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;
    localparam logic [15:0] STALL_LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] STALL_LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic                              valid;
        logic                              err;
        logic [bus_params_pkg::BUS_DW-1:0] data;
    } rsp_entry_t;

    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input int unsigned depth);
        return (addr >= base) && (addr < base + 64'(depth) * 64'd4);
    endfunction

    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input logic [63:0] base);
        return (addr - base) >> 2;
    endfunction
endpackage
`default_nettype wire

// File: rtl/instr_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_if
// Purpose  : Core instruction-fetch bus (req/gnt/rvalid/rdata/err).
// Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_if #(
    parameter int AddrWidth = bus_params_pkg::BUS_AW,
    parameter int DataWidth = bus_params_pkg::BUS_DW
);
    logic                 instr_req_i;
    logic [AddrWidth-1:0] instr_addr_i;
    logic                 instr_gnt_o;
    logic                 instr_rvalid_o;
    logic [DataWidth-1:0] instr_rdata_o;
    logic                 instr_err_o;

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
    );

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_rsp_pipe
// Purpose  : Fixed-depth shift pipeline of response entries, head registered.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_rsp_pipe
    import instr_mem_pkg::*;
#(
    parameter int Depth = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  rsp_entry_t in_entry,
    output rsp_entry_t head
);
    rsp_entry_t r_stage [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= in_entry;
            for (int i = 1; i < Depth; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign head = r_stage[Depth-1];
endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder
// Purpose  : Word-addressed program RAM answering the core fetch port with
//            in-order, fixed-latency responses. Define INSTR_MEM_STALL_EN to
//            add LFSR-driven grant backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int          AddrWidth      = bus_params_pkg::BUS_AW,
    parameter int          DataWidth      = bus_params_pkg::BUS_DW,
    parameter int          MemDepth       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int          RspLatency     = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    instr_mem_if.slave                         bus,
    input  logic                               load_we_i,
    input  logic [$clog2(MemDepth)-1:0]        load_addr_i,
    input  logic [DataWidth-1:0]               load_wdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);
    localparam int IdxW = $clog2(MemDepth);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] c_max_out = CntW'(MaxOutstanding);

    logic [DataWidth-1:0] r_mem [MemDepth];
    logic [CntW-1:0]      r_outstanding;
    logic [AddrWidth-1:0] w_addr;
    logic [IdxW-1:0]      w_idx;
    logic                 w_err;
    logic                 w_stall;
    logic                 w_gnt;
    logic                 w_xfer;
    logic                 w_rsp;
    rsp_entry_t           w_in_entry;
    rsp_entry_t           w_head;

`ifdef INSTR_MEM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= STALL_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & STALL_LFSR_TAPS)};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign w_addr = bus.instr_addr_i;
    assign w_err  = (w_addr[1:0] != 2'b00) ||
                    !addr_in_range(64'(w_addr), 64'(BaseAddr), MemDepth);
    assign w_idx  = IdxW'(word_index(64'(w_addr), 64'(BaseAddr)));
    assign w_rsp  = w_head.valid;

    // A slot whose response is on the bus this cycle is free for a new grant
    assign w_gnt  = bus.instr_req_i && rst_n && !w_stall &&
                    ((r_outstanding - CntW'(w_rsp)) < c_max_out);
    assign w_xfer = w_gnt;

    // Combinational read ahead of the write port gives read-before-write
    always_comb begin
        w_in_entry       = '0;
        w_in_entry.valid = w_xfer;
        w_in_entry.err   = w_xfer && w_err;
        if (w_xfer && !w_err) begin
            w_in_entry.data = r_mem[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (load_we_i) begin
            r_mem[load_addr_i] <= load_wdata_i;
        end
    end

    instr_mem_rsp_pipe #(
        .Depth (RspLatency)
    ) u_rsp_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_entry (w_in_entry),
        .head     (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            case ({w_xfer, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign bus.instr_gnt_o    = w_gnt;
    assign bus.instr_rvalid_o = w_head.valid;
    assign bus.instr_rdata_o  = w_head.data;
    assign bus.instr_err_o    = w_head.err;
    assign outstanding_o      = r_outstanding;
endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_responder
// Purpose  : Scoreboard bench for two responder configurations (L=1, L=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_wdata;
    logic [1:0]  out1, out3;
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_mem_if bus1 ();
    instr_mem_if bus3 ();

    instr_mem_responder #(.RspLatency(1), .MaxOutstanding(2)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1),
        .load_we_i (load_we), .load_addr_i (load_addr), .load_wdata_i (load_wdata),
        .outstanding_o (out1)
    );

    instr_mem_responder #(.RspLatency(3), .MaxOutstanding(2)) dut3 (
        .clk (clk), .rst_n (rst_n), .bus (bus3),
        .load_we_i (load_we), .load_addr_i (load_addr), .load_wdata_i (load_wdata),
        .outstanding_o (out3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop an expectation whenever a response is presented
    always @(negedge clk) if (rst_n) begin
        if (bus1.instr_rvalid_o) begin
            if (q1.size() == 0) check("l1_unexpected_rvalid", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("l1_rsp_cycle", cyc, e1.cyc + 1);
                check("l1_rsp_err", bus1.instr_err_o, e1.err);
                check("l1_rsp_data", bus1.instr_rdata_o, e1.data);
            end
        end else begin
            check("l1_idle_zero", {bus1.instr_err_o, bus1.instr_rdata_o}, 0);
        end
        check("l1_outstanding_le_max", out1 <= 2'd2, 1);
    end

    always @(negedge clk) if (rst_n) begin
        if (bus3.instr_rvalid_o) begin
            if (q3.size() == 0) check("l3_unexpected_rvalid", 1, 0);
            else begin
                e3 = q3.pop_front();
                check("l3_rsp_cycle", cyc, e3.cyc + 3);
                check("l3_rsp_err", bus3.instr_err_o, e3.err);
                check("l3_rsp_data", bus3.instr_rdata_o, e3.data);
            end
        end else begin
            check("l3_idle_zero", {bus3.instr_err_o, bus3.instr_rdata_o}, 0);
        end
        check("l3_outstanding_le_max", out3 <= 2'd2, 1);
    end

    task automatic load(input logic [9:0] idx, input logic [31:0] d);
        load_we = 1'b1; load_addr = idx; load_wdata = d;
        @(posedge clk); #1;
        load_we = 1'b0;
    endtask

    // Present a request and wait for the grant; expected wait is hand-computed
    task automatic fetch(input int which, input logic [31:0] a, input logic ex_err,
                         input logic [31:0] ex_data, input int ex_wait);
        int w;
        bit got;
        got = 1'b0;
        if (which == 1) begin bus1.instr_req_i = 1'b1; bus1.instr_addr_i = a; end
        else            begin bus3.instr_req_i = 1'b1; bus3.instr_addr_i = a; end
        for (w = 0; w < 20; w++) begin
            @(negedge clk);
            if (which == 1 && bus1.instr_gnt_o) begin
                q1.push_back('{cyc, ex_err, ex_data}); got = 1'b1;
            end else if (which == 3 && bus3.instr_gnt_o) begin
                q3.push_back('{cyc, ex_err, ex_data}); got = 1'b1;
            end
            @(posedge clk); #1;
            if (got) break;
        end
        check("gnt_timeout", got, 1);
        check("gnt_wait", w, ex_wait);
    endtask

    task automatic idle_req();
        bus1.instr_req_i = 1'b0;
        bus3.instr_req_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q1.size() != 0 || q3.size() != 0); i++) @(posedge clk);
        @(posedge clk); #1;
        check("drain_queues_empty", q1.size() + q3.size(), 0);
    endtask

    initial begin
        load_we = 1'b0; load_addr = '0; load_wdata = '0;
        bus1.instr_req_i = 1'b1; bus1.instr_addr_i = '0;
        bus3.instr_req_i = 1'b1; bus3.instr_addr_i = '0;

        // Reset state, with requests asserted to prove gnt is gated by rst_n
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt1", bus1.instr_gnt_o, 0);
        check("rst_gnt3", bus3.instr_gnt_o, 0);
        check("rst_rvalid1", bus1.instr_rvalid_o, 0);
        check("rst_rdata_err1", {bus1.instr_err_o, bus1.instr_rdata_o}, 0);
        check("rst_outstanding1", out1, 0);
        check("rst_outstanding3", out3, 0);
        idle_req();
        @(posedge clk); #1;
        rst_n = 1'b1;

        load(10'd0, 32'h0000_0013);
        load(10'd1, 32'h0010_0093);

        // Back-to-back fetch with the grant in both cycles
        fetch(1, 32'h0, 1'b0, 32'h0000_0013, 0);
        fetch(1, 32'h4, 1'b0, 32'h0010_0093, 0);
        idle_req();
        drain();

        // Out-of-range (first byte past the RAM) and misaligned addresses
        fetch(1, 32'h0000_1000, 1'b1, 32'h0, 0);
        fetch(1, 32'h0000_0002, 1'b1, 32'h0, 0);
        idle_req();
        drain();

        // Outstanding limit with latency 3: gnt follows 1,1,0 repeating
        bus3.instr_req_i = 1'b1; bus3.instr_addr_i = 32'h0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("l3_gnt_pattern", bus3.instr_gnt_o, (i % 3) != 2);
            if (bus3.instr_gnt_o) q3.push_back('{cyc, 1'b0, 32'h0000_0013});
            @(posedge clk); #1;
        end
        idle_req();
        drain();

        // Reset with two requests in flight: their responses must vanish
        bus3.instr_req_i = 1'b1; bus3.instr_addr_i = 32'h4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("l3_inflight_gnt", bus3.instr_gnt_o, 1);
            @(posedge clk); #1;
        end
        idle_req();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outstanding3", out3, 0);
        check("midrst_rvalid3", bus3.instr_rvalid_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_outstanding3", out3, 0);
        fetch(3, 32'h0, 1'b0, 32'h0000_0013, 0);
        idle_req();
        drain();

        // Load and grant to the same word in one cycle: old data returned
        load_we = 1'b1; load_addr = 10'd1; load_wdata = 32'hDEAD_BEEF;
        bus1.instr_req_i = 1'b1; bus1.instr_addr_i = 32'h4;
        @(negedge clk);
        check("collision_gnt", bus1.instr_gnt_o, 1);
        if (bus1.instr_gnt_o) q1.push_back('{cyc, 1'b0, 32'h0010_0093});
        @(posedge clk); #1;
        load_we = 1'b0;
        idle_req();
        drain();
        fetch(1, 32'h4, 1'b0, 32'hDEAD_BEEF, 0);
        idle_req();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule
`default_nettype wire
